therm_dec: RTL and testbench

Serial thermometer-to-binary decoder: the receive-side counterpart of the 4-bit-to-16-bit thermometer encoder in the data-stop path. It captures a 16-bit thermometer word on `en` and scans it one bit per clock. It then returns the 4-bit level that encoded it, plus an error flag for words the encoder cannot produce (all-zero or bubbled). It sits after the level bus, ahead of the sequence/stop control logic.

---
 rtl/therm_dec.sv | 118 +++++++++++
 tb/tb_therm_dec.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/therm_dec.sv
// rtl/therm_dec.sv - serial 16-bit thermometer to 4-bit level decoder with error flag
// Optional feature: THERM_DEC_BUBBLE_TOL_EN (bubbled words decode to popcount-1 instead of error)
module therm_dec (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d,
  input  logic        en,
  output logic [3:0]  b,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  i_q, i_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        seen_zero_q, seen_zero_d;
  logic        bubble_q, bubble_d;
  logic [3:0]  b_q, b_d;
  logic        err_q, err_d;
  logic [4:0]  lvl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= 16'd0;
      i_q         <= 4'd0;
      cnt_q       <= 5'd0;
      seen_zero_q <= 1'b0;
      bubble_q    <= 1'b0;
      b_q         <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      i_q         <= i_d;
      cnt_q       <= cnt_d;
      seen_zero_q <= seen_zero_d;
      bubble_q    <= bubble_d;
      b_q         <= b_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    i_d         = i_q;
    cnt_d       = cnt_q;
    seen_zero_d = seen_zero_q;
    bubble_d    = bubble_q;
    b_d         = b_q;
    err_d       = err_q;
    lvl         = 5'd0;
    case (state_q)
      IDLE: begin
        if (en) begin
          sh_d        = d;
          i_d         = 4'd0;
          cnt_d       = 5'd0;
          seen_zero_d = 1'b0;
          bubble_d    = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (sh_q[i_q]) begin
          cnt_d = cnt_q + 5'd1;
          if (seen_zero_q) bubble_d = 1'b1;
        end else begin
          seen_zero_d = 1'b1;
        end
        i_d = i_q + 4'd1;
        // The result is decided from the post-update counts so bit 15 is included.
        if (i_q == 4'd15) begin
          state_d = DONE;
          lvl     = cnt_d - 5'd1;
          if (cnt_d == 5'd0) begin
            b_d   = 4'd0;
            err_d = 1'b1;
          end else begin
`ifdef THERM_DEC_BUBBLE_TOL_EN
            b_d   = lvl[3:0];
            err_d = 1'b0;
`else
            if (bubble_d) begin
              b_d   = 4'd0;
              err_d = 1'b1;
            end else begin
              b_d   = lvl[3:0];
              err_d = 1'b0;
            end
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign b     = b_q;
  assign err   = err_q;
  assign valid = (state_q == DONE);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_therm_dec.sv
// tb/tb_therm_dec.sv - randomized self-checking bench for therm_dec against a popcount/shape model
module tb_therm_dec;

  logic        clk;
  logic        reset;
  logic [15:0] d;
  logic        en;
  logic [3:0]  b;
  logic        valid;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  therm_dec dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .en    (en),
    .b     (b),
    .valid (valid),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // A legal word is 2^n-1 for n>=1; level is n-1. Otherwise result depends on build.
  function automatic void model(input logic [15:0] w, output int eb, output int ee);
    int pop;
    int shape_ok;
    pop = $countones(w);
    shape_ok = (int'(w) == ((1 << pop) - 1));
    if (pop == 0) begin
      eb = 0; ee = 1;
    end else if (shape_ok != 0) begin
      eb = pop - 1; ee = 0;
    end else begin
`ifdef THERM_DEC_BUBBLE_TOL_EN
      eb = pop - 1; ee = 0;
`else
      eb = 0; ee = 1;
`endif
    end
  endfunction

  // Capture one word; returns result and the negedge count from capture to valid.
  task automatic run_word(input logic [15:0] w, input bit hold, input logic [15:0] w_after,
                          output int gb, output int ge, output int lat, output int busy_n);
    bit seen;
    @(negedge clk);
    d  = w;
    en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) en = 1'b0;
    d = w_after;
    lat = 0; busy_n = 0; seen = 0; gb = -1; ge = -1;
    while (lat < 40 && !seen) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (valid) begin
        seen = 1; gb = int'(b); ge = int'(err);
      end
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic check_word(input string tag, input logic [15:0] w, input bit lat_chk);
    int gb, ge, lat, bn, eb, ee;
    model(w, eb, ee);
    run_word(w, 1'b0, $urandom, gb, ge, lat, bn);
    chk({tag, "_b"}, gb, eb);
    chk({tag, "_err"}, ge, ee);
    if (lat_chk) chk({tag, "_lat"}, lat, 17);
  endtask

  initial begin
    int gb, ge, lat, bn, eb, ee, vcount;
    logic [15:0] w;
    reset = 1'b1; en = 1'b1; d = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_b", int'(b), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b0; en = 1'b0;

    // First word: latency, busy width, pulse width and hold of b/err.
    run_word(16'h0001, 1'b0, 16'h0000, gb, ge, lat, bn);
    chk("first_b", gb, 0);
    chk("first_err", ge, 0);
    chk("first_lat", lat, 17);
    chk("first_busy", bn, 17);
    @(negedge clk);
    chk("first_valid_fall", int'(valid), 0);
    chk("first_busy_fall", int'(busy), 0);
    chk("first_b_hold", int'(b), 0);

    // Back-to-back encoder sweep at the earliest legal capture.
    for (int lv = 0; lv < 16; lv++) begin
      w = 16'((32'd1 << (lv + 1)) - 1);
      run_word(w, 1'b0, 16'h0000, gb, ge, lat, bn);
      chk($sformatf("sweep%0d_b", lv), gb, lv);
      chk($sformatf("sweep%0d_err", lv), ge, 0);
      chk($sformatf("sweep%0d_lat", lv), lat, 17);
    end

    check_word("zero", 16'h0000, 1'b1);
    check_word("bubble", 16'h00F7, 1'b1);
`ifdef THERM_DEC_BUBBLE_TOL_EN
    chk("bubble_tol_model", int'(b), 6);
`else
    chk("bubble_strict_model", int'(err), 1);
`endif

    // en held through SCAN/DONE with d changing after capture.
    run_word(16'h000F, 1'b1, 16'hFFFF, gb, ge, lat, bn);
    chk("hold_b", gb, 3);
    chk("hold_err", ge, 0);
    run_word(16'hFFFF, 1'b1, 16'hFFFF, gb, ge, lat, bn);
    chk("hold_next_b", gb, 15);
    chk("hold_next_lat", lat, 17);
    en = 1'b0;

    // Reset on the 8th SCAN edge discards the word.
    @(negedge clk);
    d = 16'h00FF; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_b", int'(b), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_err", int'(err), 0);
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("midrst_no_valid", vcount, 0);
    check_word("after_rst", 16'h003F, 1'b1);

    // Random words: legal encodings, single-bit corruptions and arbitrary values.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0: w = 16'((32'd1 << $urandom_range(1, 16)) - 1);
        1: w = 16'((32'd1 << $urandom_range(1, 16)) - 1) ^ 16'(32'd1 << $urandom_range(0, 15));
        default: w = 16'($urandom);
      endcase
      check_word($sformatf("rnd%0d_%h", k, w), w, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
